// File: rtl/posit_encode_pipe.sv
// Two-stage posit encoder: regime/exp/fraction packing, then round-to-nearest-even and saturation.
// Latency 2 cycles. in_ready is combinational from out_ready so a stalled output fills both stages first.
module posit_encode_pipe #(
    parameter int N  = 16,
    parameter int ES = 1,
    parameter int KW = $clog2(N) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        sign,
    input  logic [KW-1:0]               k,
    input  logic [((ES > 0) ? ES : 1)-1:0] exp,
    input  logic [N-1:0]                mant,
    input  logic [1:0]                  is_special,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N-1:0]                posit
);
    localparam int BW = 3 * N;
    localparam int TW = ES + N - 1;
    localparam logic [KW:0] ONE = (KW + 1)'(1);
    localparam logic [KW:0] TWO = (KW + 1)'(2);

    logic           w_s1_en, w_s2_en;
    logic [KW:0]    w_k_ext, w_reg_len;
    logic [BW-1:0]  w_regime, w_body;
    logic [TW-1:0]  w_tail;
    logic           w_sat_max, w_sat_min;
    int             w_k_int;
    logic           w_unused;

    logic           r_s1_valid, r_sign, r_sat_max, r_sat_min, r_zero, r_nan;
    logic [BW-1:0]  r_body;
    logic           r_out_valid;
    logic [N-1:0]   r_posit;

    logic [N-2:0]   w_trunc, w_mag;
    logic           w_guard, w_sticky, w_round;
    logic [N-1:0]   w_mag_ext, w_posit;

    assign w_s2_en   = !r_out_valid || out_ready;
    assign w_s1_en   = !r_s1_valid || w_s2_en;
    assign in_ready  = w_s1_en;
    assign out_valid = r_out_valid;
    assign posit     = r_posit;

    // The hidden bit of mant (and exp when ES=0) carries no information.
    assign w_unused = ^{mant[N-1], exp};

    generate
        if (ES > 0) begin : g_exp
            assign w_tail = {exp[ES-1:0], mant[N-2:0]};
        end else begin : g_noexp
            assign w_tail = mant[N-2:0];
        end
    endgenerate

    always_comb begin
        w_k_ext   = {k[KW-1], k};
        w_k_int   = int'($signed(k));
        w_sat_max = (w_k_int > N - 2);
        w_sat_min = (w_k_int < -(N - 1));
        if (!k[KW-1]) begin
            w_reg_len = w_k_ext + TWO;
            w_regime  = ~({BW{1'b1}} >> (w_k_ext + ONE));
        end else begin
            w_reg_len = ONE - w_k_ext;
            w_regime  = {1'b1, {(BW-1){1'b0}}} >> (-w_k_ext);
        end
        w_body = ({w_tail, {(BW-TW){1'b0}}} >> w_reg_len) | w_regime;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_body     <= '0;
            r_sign     <= 1'b0;
            r_sat_max  <= 1'b0;
            r_sat_min  <= 1'b0;
            r_zero     <= 1'b0;
            r_nan      <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            r_body     <= w_body;
            r_sign     <= sign;
            r_sat_max  <= w_sat_max;
            r_sat_min  <= w_sat_min;
            r_zero     <= is_special[1];
            r_nan      <= is_special[0];
        end
    end

    // Rounding never leaves maxpos and never reaches zero.
    always_comb begin
        w_trunc  = r_body[BW-1 -: N-1];
        w_guard  = r_body[BW-N];
        w_sticky = |r_body[BW-N-1:0];
        w_round  = w_guard & (w_trunc[0] | w_sticky);
        if (&w_trunc) begin
            w_mag = w_trunc;
        end else begin
            w_mag = w_trunc + (N-1)'(w_round);
        end
        if (w_mag == '0) begin
            w_mag = (N-1)'(1);
        end
        if (r_sat_max) begin
            w_mag = '1;
        end else if (r_sat_min) begin
            w_mag = (N-1)'(1);
        end
        w_mag_ext = {1'b0, w_mag};
        w_posit   = r_sign ? (~w_mag_ext + N'(1)) : w_mag_ext;
        if (r_nan) begin
            w_posit = {1'b1, {(N-1){1'b0}}};
        end else if (r_zero) begin
            w_posit = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_posit     <= '0;
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_valid;
            r_posit     <= w_posit;
        end
    end
endmodule
